// File: rtl/mram_burst_pkg.sv
// Shared types and helpers for the MRAM burst transmit controller.
// Optional feature macro: MRAM_TX_GAP_EN (inserts idle cycles between words).
package mram_burst_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StLoad,
        StShift,
        StNext,
        StGap,
        StDone
    } state_e;

    localparam logic [1:0] WSEL_FULL = 2'b11;
    localparam logic [1:0] WSEL_LO   = 2'b01;
    localparam logic [1:0] WSEL_HI   = 2'b10;

    // 00 has no meaning on the link, so it is treated as a full-word request.
    function automatic logic [1:0] coerce_wsel(input logic [1:0] sel);
        return (sel == 2'b00) ? WSEL_FULL : sel;
    endfunction

    // Number of bits shifted out for one word with the given (coerced) selector.
    function automatic int unsigned nbits(input logic [1:0] sel, input int unsigned bus_width);
        return (sel == WSEL_LO || sel == WSEL_HI) ? bus_width / 2 : bus_width;
    endfunction

endpackage

// File: rtl/mram_burst_tx_ctrl_if.sv
// Command, MRAM-pin and shifter-control signals of the burst transmit controller.
// Optional feature macro: MRAM_TX_GAP_EN (no effect on this interface).
interface mram_burst_tx_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                  en;
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic [1:0]            word_sel;

    logic [ADDR_WIDTH-1:0] mram_addr;
    logic                  mram_ce_n;
    logic                  mram_oe_n;
    logic                  load;
    logic                  send_data;
    logic [1:0]            word_sel_q;
    logic                  bit_valid;
    logic                  busy;
    logic                  done;

    // The controller side.
    modport master (
        input  en, start, abort, start_addr, burst_len, word_sel,
        output mram_addr, mram_ce_n, mram_oe_n, load, send_data, word_sel_q, bit_valid, busy,
               done
    );

    // The command decoder / shifter side.
    modport slave (
        output en, start, abort, start_addr, burst_len, word_sel,
        input  mram_addr, mram_ce_n, mram_oe_n, load, send_data, word_sel_q, bit_valid, busy,
               done
    );
endinterface

// File: rtl/mram_rd_timer.sv
// Loadable down-counter with a zero flag; shared by the wait, bit and gap phases.
// Optional feature macro: MRAM_TX_GAP_EN (no effect on this module).
module mram_rd_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/mram_burst_tx_ctrl.sv
// Sequences MRAM burst reads into a parallel-to-serial shifter:
// address, read latency, load strobe, shift window, advance address, per word.
// Optional feature macro: MRAM_TX_GAP_EN (GAP_CYCLES idle cycles between words).
module mram_burst_tx_ctrl
    import mram_burst_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mram_burst_tx_ctrl_if.master bus
);
    localparam int unsigned MAX_A   = (BUS_WIDTH > RD_WAIT) ? BUS_WIDTH : RD_WAIT;
    localparam int unsigned CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned TW      = $clog2(CNT_MAX);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
    logic [1:0]            sel_q, sel_d;

    logic                  tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]         tmr_val;

    logic [ADDR_WIDTH-1:0] mram_addr_q;
    logic                  ce_oe_n_q, ce_oe_n_d;
    logic                  load_q, send_q, bit_valid_q, busy_q, done_q;
    logic                  load_g, send_g;

    mram_rd_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .value(tmr_val),
        .zero (tmr_zero)
    );

    // State and latched burst parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            words_left_q <= '0;
            sel_q        <= WSEL_FULL;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            words_left_q <= words_left_d;
            sel_q        <= sel_d;
        end
    end

    // Next-state, latch updates and timer control; abort overrides the enable freeze.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        sel_d        = sel_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_val      = '0;

        if (bus.abort && (state_q != StIdle) && (state_q != StDone)) begin
            state_d = StDone;
        end else if (bus.en) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        cur_addr_d   = bus.start_addr;
                        words_left_d = bus.burst_len;
                        sel_d        = coerce_wsel(bus.word_sel);
                        state_d      = (bus.burst_len == '0) ? StDone : StAddr;
                    end
                end
                StAddr: begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RD_WAIT - 1);
                    state_d  = StWait;
                end
                StWait: begin
                    if (tmr_zero) state_d = StLoad;
                    else          tmr_dec = 1'b1;
                end
                StLoad: begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(nbits(sel_q, BUS_WIDTH) - 1);
                    state_d  = StShift;
                end
                StShift: begin
                    if (tmr_zero) state_d = StNext;
                    else          tmr_dec = 1'b1;
                end
                StNext: begin
                    words_left_d = words_left_q - 1'b1;
                    cur_addr_d   = cur_addr_q + 1'b1;
                    if (words_left_q == LEN_WIDTH'(1)) begin
                        state_d = StDone;
                    end else begin
`ifdef MRAM_TX_GAP_EN
                        tmr_load = 1'b1;
                        tmr_val  = TW'(GAP_CYCLES - 1);
                        state_d  = StGap;
`else
                        state_d  = StAddr;
`endif
                    end
                end
`ifdef MRAM_TX_GAP_EN
                StGap: begin
                    if (tmr_zero) state_d = StAddr;
                    else          tmr_dec = 1'b1;
                end
`endif
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // MRAM is selected from address issue until the shifter has loaded the word.
    always_comb begin
        ce_oe_n_d = 1'b1;
        if (state_d == StAddr || state_d == StWait || state_d == StLoad) begin
            ce_oe_n_d = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mram_addr_q <= '0;
            ce_oe_n_q   <= 1'b1;
            load_q      <= 1'b0;
            send_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (state_d == StAddr) mram_addr_q <= cur_addr_d;
            ce_oe_n_q   <= ce_oe_n_d;
            load_q      <= (state_d == StLoad);
            send_q      <= (state_d == StShift);
            bit_valid_q <= send_g;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
        end
    end

    // Strobes are masked by en so the shifter never sees a shift while the FSM is frozen.
    assign load_g = load_q & bus.en;
    assign send_g = send_q & bus.en;

    assign bus.mram_addr  = mram_addr_q;
    assign bus.mram_ce_n  = ce_oe_n_q;
    assign bus.mram_oe_n  = ce_oe_n_q;
    assign bus.load       = load_g;
    assign bus.send_data  = send_g;
    assign bus.word_sel_q = sel_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_mram_burst_tx_ctrl.sv
// Bench for mram_burst_tx_ctrl with a behavioural MRAM and LSB-first shifter.
// Optional feature macro: MRAM_TX_GAP_EN (changes expected burst timing).
module tb_mram_burst_tx_ctrl;
    localparam int unsigned RD_WAIT = 2;
`ifdef MRAM_TX_GAP_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mram_burst_tx_ctrl_if #(.ADDR_WIDTH(18), .LEN_WIDTH(8)) bus ();

    mram_burst_tx_ctrl #(
        .BUS_WIDTH (16),
        .ADDR_WIDTH(18),
        .LEN_WIDTH (8),
        .RD_WAIT   (RD_WAIT),
        .GAP_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        if (a >= 18'h100 && a < 18'h110) return 16'hA5C3 + 16'(a - 18'h100);
        return a[15:0] ^ 16'h1234;
    endfunction

    // MRAM model: data only valid once the chip has been selected for RD_WAIT cycles.
    logic [3:0]  low_cnt;
    logic [15:0] mram_dq;
    always @(posedge clk) begin
        if (bus.mram_ce_n || bus.mram_oe_n) low_cnt <= 4'd0;
        else if (low_cnt != 4'd15)          low_cnt <= low_cnt + 4'd1;
    end
    assign mram_dq = (!bus.mram_ce_n && !bus.mram_oe_n && low_cnt >= 4'(RD_WAIT))
                     ? mem_word(bus.mram_addr) : 16'hDEAD;

    // Shifter model: LSB first; the high-byte selector pre-shifts the upper byte down.
    logic [15:0] sh;
    logic        sbit;
    always @(posedge clk) begin
        if (rst) begin
            sh   <= 16'h0;
            sbit <= 1'b0;
        end else if (bus.en) begin
            if (bus.load) begin
                sh <= (bus.word_sel_q == 2'b10) ? {8'h00, mram_dq[15:8]} : mram_dq;
            end else if (bus.send_data) begin
                sbit <= sh[0];
                sh   <= {1'b0, sh[15:1]};
            end
        end
    end

    logic [63:0] obs_bits;
    int          obs_nbits, obs_loads, obs_ce_low, obs_done_cnt, obs_done_at;
    logic [17:0] obs_load_addr [0:7];
    logic        obs_busy_done, obs_busy_after, obs_send_done;

    task automatic drive_start(input logic [17:0] addr, input logic [7:0] len,
                               input logic [1:0] sel, input logic with_abort);
        @(posedge clk);
        #1;
        bus.start_addr = addr;
        bus.burst_len  = len;
        bus.word_sel   = sel;
        bus.start      = 1'b1;
        bus.abort      = with_abort;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        // Scramble inputs to show the latched copies are used.
        bus.start_addr = ~addr;
        bus.burst_len  = 8'd7;
        bus.word_sel   = (sel == 2'b01) ? 2'b11 : 2'b01;
    endtask

    // n counts negedges after the start-sampling edge; done at n means n cycles after start.
    task automatic run_burst(input logic [17:0] addr, input logic [7:0] len, input logic [1:0] sel,
                             input int abort_at, input int en_off_at, input logic with_abort);
        int  n;
        bit  seen, fin;
        obs_bits = '0; obs_nbits = 0; obs_loads = 0; obs_ce_low = 0;
        obs_done_cnt = 0; obs_done_at = 0;
        obs_busy_done = 1'b0; obs_busy_after = 1'b1; obs_send_done = 1'b1;
        for (int i = 0; i < 8; i++) obs_load_addr[i] = '0;
        drive_start(addr, len, sel, with_abort);
        n = 0; seen = 0; fin = 0;
        while (!fin && n < 300) begin
            @(negedge clk);
            n++;
            if (seen) begin
                obs_busy_after = bus.busy;
                fin = 1;
            end else begin
                if (bus.bit_valid && obs_nbits < 64) begin
                    obs_bits[obs_nbits] = sbit;
                    obs_nbits++;
                end
                if (bus.load) begin
                    if (obs_loads < 8) obs_load_addr[obs_loads] = bus.mram_addr;
                    obs_loads++;
                end
                if (!bus.mram_ce_n) obs_ce_low++;
                if (bus.done) begin
                    obs_done_cnt++;
                    obs_done_at   = n;
                    obs_busy_done = bus.busy;
                    obs_send_done = bus.send_data;
                    seen = 1;
                end
            end
            bus.abort = (n == abort_at);
            if (n == en_off_at)     bus.en = 1'b0;
            if (n == en_off_at + 3) bus.en = 1'b1;
        end
        bus.abort = 1'b0;
        if (!fin) check("timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int dcount;
        rst = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
        bus.start_addr = '0; bus.burst_len = '0; bus.word_sel = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(bus.mram_addr), 32'h0);
        check("rst_ce_n", 32'(bus.mram_ce_n), 32'h1);
        check("rst_oe_n", 32'(bus.mram_oe_n), 32'h1);
        check("rst_strobes", 32'({bus.load, bus.send_data, bus.bit_valid}), 32'h0);
        check("rst_busy_done", 32'({bus.busy, bus.done}), 32'h0);
        check("rst_wsel", 32'(bus.word_sel_q), 32'h3);
        rst = 1'b0;

        // T1: single full word.
        run_burst(18'h100, 8'd1, 2'b11, -1, 1000, 1'b0);
        check("t1_done_at", 32'(obs_done_at), 32'd22);
        check("t1_loads", 32'(obs_loads), 32'd1);
        check("t1_addr", 32'(obs_load_addr[0]), 32'h100);
        check("t1_nbits", 32'(obs_nbits), 32'd16);
        check("t1_word", 32'(obs_bits[15:0]), 32'hA5C3);
        check("t1_ce_low", 32'(obs_ce_low), 32'd4);
        check("t1_busy_after", 32'(obs_busy_after), 32'h0);

        // T2: three low bytes.
        run_burst(18'h100, 8'd3, 2'b01, -1, 1000, 1'b0);
        check("t2_done_at", 32'(obs_done_at), 32'(40 + 2 * GAP));
        check("t2_loads", 32'(obs_loads), 32'd3);
        check("t2_addr0", 32'(obs_load_addr[0]), 32'h100);
        check("t2_addr1", 32'(obs_load_addr[1]), 32'h101);
        check("t2_addr2", 32'(obs_load_addr[2]), 32'h102);
        check("t2_nbits", 32'(obs_nbits), 32'd24);
        check("t2_b0", 32'(obs_bits[7:0]), 32'hC3);
        check("t2_b1", 32'(obs_bits[15:8]), 32'hC4);
        check("t2_b2", 32'(obs_bits[23:16]), 32'hC5);
        check("t2_done_cnt", 32'(obs_done_cnt), 32'd1);

        // T3: empty burst.
        run_burst(18'h100, 8'd0, 2'b11, -1, 1000, 1'b0);
        check("t3_done_at", 32'(obs_done_at), 32'd1);
        check("t3_loads", 32'(obs_loads), 32'd0);
        check("t3_ce_low", 32'(obs_ce_low), 32'd0);
        check("t3_busy_done", 32'(obs_busy_done), 32'h1);
        check("t3_busy_after", 32'(obs_busy_after), 32'h0);

        // T4: address wrap.
        run_burst(18'h3FFFF, 8'd2, 2'b00, -1, 1000, 1'b0);
        check("t4_done_at", 32'(obs_done_at), 32'(43 + GAP));
        check("t4_addr0", 32'(obs_load_addr[0]), 32'h3FFFF);
        check("t4_addr1", 32'(obs_load_addr[1]), 32'h0);
        check("t4_w0", 32'(obs_bits[15:0]), 32'hEDCB);
        check("t4_w1", 32'(obs_bits[31:16]), 32'h1234);

        // T5: abort during the 5th shift cycle, then a fresh burst.
        run_burst(18'h100, 8'd2, 2'b11, 9, 1000, 1'b0);
        check("t5_done_at", 32'(obs_done_at), 32'd10);
        check("t5_send_at_done", 32'(obs_send_done), 32'h0);
        check("t5_loads", 32'(obs_loads), 32'd1);
        check("t5_busy_after", 32'(obs_busy_after), 32'h0);
        run_burst(18'h101, 8'd1, 2'b01, -1, 1000, 1'b0);
        check("t5b_done_at", 32'(obs_done_at), 32'd14);
        check("t5b_byte", 32'(obs_bits[7:0]), 32'hC4);

        // T6: enable dropped for 3 cycles mid-shift.
        run_burst(18'h100, 8'd1, 2'b11, -1, 10, 1'b0);
        check("t6_done_at", 32'(obs_done_at), 32'd25);
        check("t6_nbits", 32'(obs_nbits), 32'd16);
        check("t6_word", 32'(obs_bits[15:0]), 32'hA5C3);

        // T7: start and abort together in IDLE; start wins. High byte.
        run_burst(18'h100, 8'd1, 2'b10, -1, 1000, 1'b1);
        check("t7_done_at", 32'(obs_done_at), 32'd14);
        check("t7_loads", 32'(obs_loads), 32'd1);
        check("t7_byte", 32'(obs_bits[7:0]), 32'hA5);

        // T8: reset mid-burst returns to IDLE with no done pulse.
        drive_start(18'h100, 8'd2, 2'b11, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t8_busy", 32'(bus.busy), 32'h0);
        check("t8_ce_n", 32'(bus.mram_ce_n), 32'h1);
        check("t8_send", 32'(bus.send_data), 32'h0);
        rst = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        check("t8_no_done", 32'(dcount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
